// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start / slew controller feeding a PWM generator: slews duty_cycle toward a
// commanded target and sequences frequency changes through a ramp to zero duty.
module pwm_duty_ramp_ctrl #(
  parameter int clk_frequency = 450_000_000,
  parameter int step_rate_hz  = 10_000,
  parameter int STEP          = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic [1:0] cmd_freq_select,
  output logic [1:0] freq_select,
  output logic [7:0] duty_cycle,
  output logic       busy,
  output logic       at_target,
  output logic [1:0] state_dbg
);

  localparam int TICK_DIV = clk_frequency / step_rate_hz;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [8:0] STEP_W = 9'(STEP);
  localparam logic [7:0] STEP_B = 8'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, RAMP_DOWN, SWITCH} state_t;

  state_t          state;
  logic [7:0]      target_duty;
  logic [1:0]      target_freq;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            tick;

  // One step toward goal; lands exactly on goal when closer than STEP, so no
  // overshoot and no 8-bit wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
    logic [8:0] diff;
    if (goal >= cur) begin
      diff = {1'b0, goal} - {1'b0, cur};
      step_toward = (diff <= STEP_W) ? goal : cur + STEP_B;
    end else begin
      diff = {1'b0, cur} - {1'b0, goal};
      step_toward = (diff <= STEP_W) ? goal : cur - STEP_B;
    end
  endfunction

  // Handshake: a command transfers on any cycle where cmd_valid & cmd_ready;
  // cmd_ready is combinational and never depends on cmd_valid.
  assign cmd_ready = enable & ((state == IDLE) | (state == RAMP));
  assign accept    = cmd_valid & cmd_ready;
  assign tick      = (cnt == CNT_MAX);
  assign busy      = (state != IDLE);
  assign at_target = (state == IDLE) & (duty_cycle == target_duty);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      duty_cycle  <= 8'd0;
      freq_select <= 2'b00;
      target_duty <= 8'd0;
      target_freq <= 2'b00;
      cnt         <= '0;
    end else if (!enable) begin
      state       <= IDLE;
      duty_cycle  <= 8'd0;
      target_duty <= 8'd0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            target_duty <= cmd_duty;
            target_freq <= cmd_freq_select;
            state       <= (cmd_freq_select == freq_select) ? RAMP : RAMP_DOWN;
          end
        end
        RAMP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          // The step in an accept cycle still aims at the old target.
          if (tick) duty_cycle <= step_toward(duty_cycle, target_duty);
          if (accept) begin
            target_duty <= cmd_duty;
            target_freq <= cmd_freq_select;
            if (cmd_freq_select != freq_select) state <= RAMP_DOWN;
          end else if (duty_cycle == target_duty) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        RAMP_DOWN: begin
          if (duty_cycle == 8'd0) begin
            state <= SWITCH;
            cnt   <= '0;
          end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) duty_cycle <= step_toward(duty_cycle, 8'd0);
          end
        end
        SWITCH: begin
          freq_select <= target_freq;
          state       <= RAMP;
          cnt         <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
Soft-start/slew controller that sits directly upstream of the PWM generator and drives its freq_select and duty_cycle inputs. It accepts duty/frequency commands over a valid/ready handshake. It slews duty_cycle toward the commanded target at a fixed, parameterised rate. A frequency change ramps duty down to 0, switches frequency, then ramps back up, so the PWM output never jumps abruptly.

Parameters:
clk_frequency, 450_000_000, system clock frequency in Hz; matches the PWM generator.
step_rate_hz, 10_000, duty-step tick rate; TICK_DIV = clk_frequency/step_rate_hz; must be >= 1.
STEP, 1, duty LSBs moved per tick; range 1..255.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  1 = normal operation; 0 = force PWM off
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_duty  input  8  target duty, 0-255
cmd_freq_select  input  2  target frequency code, 00/01/10/11
freq_select  output  2  frequency code to the PWM generator
duty_cycle  output  8  duty to the PWM generator
busy  output  1  state != IDLE
at_target  output  1  IDLE and duty_cycle == target duty

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; duty_cycle=0; freq_select=00; target_duty=0; target_freq=00; tick counter=0.
  - Outputs: busy=0, at_target=1, cmd_ready=enable.
- States: IDLE, RAMP, RAMP_DOWN, SWITCH.
- cmd_ready = enable & (state==IDLE | state==RAMP), combinational. Accept = cmd_valid & cmd_ready; on accept, latch target_duty<=cmd_duty and target_freq<=cmd_freq_select.
- Tick counter:
  - Width $clog2(TICK_DIV), minimum 1 bit. Counts 0..TICK_DIV-1 and wraps; tick = (count==TICK_DIV-1).
  - Cleared on every entry into RAMP or RAMP_DOWN from IDLE or SWITCH; not cleared on retarget within RAMP.
  - Held at 0 in IDLE and SWITCH. TICK_DIV=1 gives a tick every cycle.
- Step rule: on a tick, duty moves STEP toward the goal. If |goal-duty| <= STEP, duty=goal (no overshoot, no 8-bit wrap).
- IDLE:
  - Accept with cmd_freq_select==freq_select -> RAMP.
  - Accept with a different frequency -> RAMP_DOWN.
  - Otherwise stay in IDLE.
- RAMP (goal=target_duty):
  - When duty_cycle==target_duty and there is no accept this cycle -> IDLE, no tick required. A no-op command exits after 1 cycle in RAMP.
  - Accept, same frequency: retarget; the step taken in the accept cycle uses the old target.
  - Accept, different frequency -> RAMP_DOWN next cycle.
- RAMP_DOWN (goal=0): when duty_cycle==0 -> SWITCH. If already 0 on entry, go to SWITCH next cycle.
- SWITCH: freq_select<=target_freq for one cycle, then -> RAMP.
- Latency:
  - duty_cycle and freq_select are registered and change on the clock edge of the tick or SWITCH cycle.
  - freq_select changes only while duty_cycle==0.
- enable=0 (any state, sync):
  - Next edge: duty_cycle=0, state=IDLE, target_duty=0, tick counter=0. freq_select holds its value.
  - cmd_ready=0, so cmd_valid is ignored.
  - Re-enable: IDLE with cmd_ready=1. There is no auto-resume.
- at_target = (state==IDLE) & (duty_cycle==target_duty).
- Reset asserted mid-ramp: immediate return to reset values, with no wait for the clock.

Test Plan:
Use clk_frequency=100, step_rate_hz=25 (TICK_DIV=4), STEP=1 unless stated.
1. Hold resetn=0, then release -> duty_cycle=0, freq_select=00, busy=0, at_target=1, cmd_ready=1.
2. cmd duty=5 freq=00 -> busy=1; duty 1,2,3,4,5 every 4th cycle; IDLE after ~20 cycles; at_target=1.
3. From duty=5/freq=00, cmd duty=3 freq=10 -> duty ramps 5->0, then SWITCH sets freq_select=10, then ramps 0->3. cmd_ready=0 during RAMP_DOWN and SWITCH. freq_select is never 10 while duty!=0.
4. Ramp toward 200; at duty=10 issue same-frequency cmd duty=4 -> accepted (ready=1), duty ramps down to 4 without a tick-phase reset, then IDLE.
5. Deassert enable at duty=7 mid-ramp -> next cycle duty=0, busy=0, cmd_ready=0, cmd_valid ignored. Reassert -> cmd_ready=1, duty stays 0.
6. STEP=16, cmd duty=250 -> duty 16,32,...,240,250 (clamped, no wrap). Then assert resetn=0 asynchronously mid-ramp -> duty_cycle=0 before the next clock edge.
